// File: rtl/ib_rx_fifo.sv
// ib_rx_fifo: byte FIFO from the UART receiver to the IB transponder.
// Bytes are handed downstream through a four-phase data_available /
// data_ack_n handshake. rts uses hysteresis so the host pauses before
// the buffer can overflow.
module ib_rx_fifo #(
    parameter int DEPTH    = 16,
    parameter int RTS_HIGH = 12,
    parameter int RTS_LOW  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic [7:0]                 data,
    output logic                       data_available,
    input  logic                       data_ack_n,
    output logic                       rts,
    output logic                       overflow,
    input  logic                       overflow_clr,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] HI_LVL   = LW'(RTS_HIGH);
    localparam logic [LW-1:0] LO_LVL   = LW'(RTS_LOW);

    typedef enum logic [1:0] {IDLE, PRESENT, ACKED} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      data_q, data_d;
    logic            rts_q, rts_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      mem_q [DEPTH];

    logic            wr_en;
    logic            drop;
    logic            pop;

    // Downstream handshake: present a byte, pop on ack, wait for ack release.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                // Uses the pre-write level, so a byte written this cycle
                // is presented on the next one.
                if (level_q != '0 && data_ack_n) begin
                    data_d  = mem_q[rd_ptr_q];
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (!data_ack_n) begin
                    pop     = 1'b1;
                    state_d = ACKED;
                end
            end
            ACKED: begin
                if (data_ack_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer, level, flow-control and overflow bookkeeping.
    always_comb begin
        wr_en    = in_valid && (level_q != FULL_LVL);
        drop     = in_valid && (level_q == FULL_LVL);
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // Hysteresis on the post-update level; between thresholds rts holds.
        rts_d = rts_q;
        if (level_d >= HI_LVL)      rts_d = 1'b1;
        else if (level_d <= LO_LVL) rts_d = 1'b0;
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (overflow_clr) ovf_d = 1'b0;
        if (drop)         ovf_d = 1'b1;
    end

    // State registers; reset discards all buffered bytes via the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= 8'h00;
            rts_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            rts_q    <= rts_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data;
    end

    assign data           = data_q;
    assign data_available = (state_q == PRESENT);
    assign rts            = rts_q;
    assign overflow       = ovf_q;
    assign level          = level_q;

endmodule

// File: tb/tb_ib_rx_fifo.sv
// Testbench for ib_rx_fifo: queue-based reference model plus a monitor
// that checks every presented byte, level, rts and overflow each cycle.
module tb_ib_rx_fifo;

    localparam int DEPTH    = 16;
    localparam int RTS_HIGH = 12;
    localparam int RTS_LOW  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] data;
    logic       data_available;
    logic       data_ack_n;
    logic       rts;
    logic       overflow;
    logic       overflow_clr;
    logic [$clog2(DEPTH):0] level;

    ib_rx_fifo #(.DEPTH(DEPTH), .RTS_HIGH(RTS_HIGH), .RTS_LOW(RTS_LOW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .data(data), .data_available(data_available), .data_ack_n(data_ack_n),
        .rts(rts), .overflow(overflow), .overflow_clr(overflow_clr), .level(level)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: FIFO contents as a queue; rts/overflow from the rules.
    logic [7:0] mq [$];
    bit  m_rts = 0;
    bit  m_ovf = 0;
    bit  m_pop, m_push;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_rts = 0;
            m_ovf = 0;
        end else begin
            m_pop  = data_available && !data_ack_n;
            m_push = in_valid && (mq.size() < DEPTH);
            if (m_pop && mq.size() > 0) void'(mq.pop_front());
            if (m_push) mq.push_back(in_data);
            if (mq.size() >= RTS_HIGH)     m_rts = 1;
            else if (mq.size() <= RTS_LOW) m_rts = 0;
            if (overflow_clr) m_ovf = 0;
            if (in_valid && !m_push) m_ovf = 1;
        end
    end

    // Monitor: compare DUT state with the model away from the active edge.
    bit chk_en = 0;
    bit prev_dav = 0;
    bit saw_drop = 0;
    int n_pres = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("level", int'(level), mq.size());
            chk("rts", int'(rts), int'(m_rts));
            chk("overflow", int'(overflow), int'(m_ovf));
            if (data_available) begin
                chk("present_nonempty", int'(mq.size() > 0), 1);
                if (mq.size() > 0) chk("data", int'(data), int'(mq[0]));
                if (!prev_dav) n_pres++;
                if (data == 8'h90 || data == 8'h91) saw_drop = 1;
            end
            prev_dav = data_available;
        end
    end

    // Random downstream acker used for the ordering phase.
    bit auto_ack = 0;
    always @(negedge clk) begin
        if (auto_ack) begin
            if (data_available && data_ack_n) begin
                if ($urandom_range(0, 1) == 1) data_ack_n = 1'b0;
            end else if (!data_ack_n) begin
                data_ack_n = 1'b1;
            end
        end
    end

    task automatic wr(input logic [7:0] v);
        in_data  = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_dav(input string nm);
        int t = 0;
        while (!data_available && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk(nm, int'(data_available), 1);
    endtask

    task automatic do_ack();
        wait_dav("ack_wait_present");
        if (data_available) begin
            data_ack_n = 1'b0;
            @(negedge clk);
            data_ack_n = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int t;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        data_ack_n = 1'b1; overflow_clr = 1'b0;

        // Reset and idle
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("rst_data", int'(data), 0);
        chk("rst_dav", int'(data_available), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_rts", int'(rts), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("idle_dav", int'(data_available), 0);
        end

        // Single byte, two-cycle latency
        wr(8'hA5);
        chk("lat1_dav", int'(data_available), 0);
        @(negedge clk);
        chk("lat2_dav", int'(data_available), 1);
        chk("lat2_data", int'(data), 8'hA5);
        data_ack_n = 1'b0;
        @(negedge clk);
        chk("ack_dav", int'(data_available), 0);
        chk("ack_level", int'(level), 0);
        data_ack_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_ack_idle", int'(data_available), 0);
        end

        // Ack held low in IDLE blocks presentation until released
        data_ack_n = 1'b0;
        wr(8'h3C);
        repeat (4) begin
            @(negedge clk);
            chk("ack_low_idle", int'(data_available), 0);
        end
        data_ack_n = 1'b1;
        do_ack();

        // Ordering and wrap-around with random acks
        p0 = n_pres;
        auto_ack = 1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(2, 4)) @(negedge clk);
            wr(8'(i));
        end
        t = 0;
        while ((level != 0 || data_available || !data_ack_n) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("order_drained", int'(level), 0);
        chk("order_count", n_pres - p0, 40);
        auto_ack = 0;
        data_ack_n = 1'b1;
        repeat (3) @(negedge clk);

        // Flow control hysteresis
        for (int i = 0; i < 11; i++) wr(8'h40 + 8'(i));
        chk("rts_at_11", int'(rts), 0);
        wr(8'h4B);
        chk("rts_at_12", int'(rts), 1);
        repeat (7) do_ack();
        chk("fc_level5", int'(level), 5);
        chk("fc_rts5", int'(rts), 1);
        do_ack();
        chk("fc_level4", int'(level), 4);
        chk("fc_rts4", int'(rts), 0);
        repeat (4) do_ack();
        chk("fc_empty", int'(level), 0);

        // Overflow: 17th byte dropped, set wins over clear
        for (int i = 0; i < 17; i++) wr(8'h80 + 8'(i));
        chk("ovf_level", int'(level), 16);
        chk("ovf_set", int'(overflow), 1);
        in_data = 8'h91; in_valid = 1'b1; overflow_clr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; overflow_clr = 1'b0;
        chk("ovf_set_wins", int'(overflow), 1);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        chk("ovf_cleared", int'(overflow), 0);
        repeat (16) do_ack();
        chk("ovf_drained", int'(level), 0);
        chk("ovf_no_dropped_byte", int'(saw_drop), 0);

        // Simultaneous write and pop at level 3, then reset mid-transfer
        wr(8'hC0); wr(8'hC1); wr(8'hC2);
        wait_dav("simul_present");
        data_ack_n = 1'b0; in_valid = 1'b1; in_data = 8'hC3;
        @(negedge clk);
        in_valid = 1'b0; data_ack_n = 1'b1;
        chk("simul_level", int'(level), 3);
        wait_dav("rst_mid_present");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_dav", int'(data_available), 0);
        chk("rst_mid_level", int'(level), 0);
        repeat (5) begin
            @(negedge clk);
            chk("rst_mid_idle", int'(data_available), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
